// File: rtl/plic_claim_sequencer.sv
// Claim/complete engine that services PLIC targets on behalf of non-CPU agents over one
// shared register-bus master port, arbitrating round-robin between targets.
module plic_claim_sequencer #(
    parameter int unsigned N_TARGET  = 2,
    parameter int unsigned SRCW      = 5,
    parameter logic [31:0] CC_BASE   = 32'h0C20_0004,
    parameter logic [31:0] CC_STRIDE = 32'h0000_1000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_TARGET-1:0]        eip_i,
    output logic                       reg_valid_o,
    output logic                       reg_write_o,
    output logic [31:0]                reg_addr_o,
    output logic [31:0]                reg_wdata_o,
    output logic [3:0]                 reg_wstrb_o,
    input  logic [31:0]                reg_rdata_i,
    input  logic                       reg_ready_i,
    input  logic                       reg_error_i,
    output logic [N_TARGET-1:0]        irq_valid_o,
    output logic [N_TARGET*SRCW-1:0]   irq_id_o,
    input  logic [N_TARGET-1:0]        irq_ready_i,
    input  logic [N_TARGET-1:0]        done_valid_i,
    output logic [N_TARGET-1:0]        done_ready_o,
    output logic                       err_o,
    output logic [1:0]                 dbg_state_o
);
    localparam int unsigned TW = (N_TARGET > 1) ? $clog2(N_TARGET) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLAIM = 2'd1, S_COMPLETE = 2'd2} bus_state_e;
    typedef enum logic [1:0] {A_FREE = 2'd0, A_OFFER = 2'd1, A_BUSY = 2'd2} agent_state_e;

    bus_state_e      state_q;
    agent_state_e    agent_q [N_TARGET];
    logic [SRCW-1:0] id_q    [N_TARGET];
    logic [TW-1:0]   rr_q, sel_q;
    logic            reg_valid_q, reg_write_q, err_q;
    logic [31:0]     reg_addr_q, reg_wdata_q;
    logic [3:0]      reg_wstrb_q;

    logic [N_TARGET-1:0] claim_req, cpl_req;
    logic                use_cpl_d, grant_d;
    logic [TW-1:0]       win_d, rr_d;
    logic                unused_rdata_bits;

    // First requester at or after ptr, wrapping modulo N_TARGET.
    function automatic logic [TW-1:0] rr_pick(input logic [N_TARGET-1:0] req,
                                              input logic [TW-1:0] ptr);
        logic [TW-1:0] pick;
        logic [TW-1:0] cand;
        int unsigned   idx;
        pick = '0;
        for (int unsigned i = 0; i < N_TARGET; i++) begin
            idx  = (N_TARGET - 1 - i + 32'(ptr)) % N_TARGET;
            cand = TW'(idx);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    always_comb begin
        claim_req = '0;
        cpl_req   = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            claim_req[t] = eip_i[t] && (agent_q[t] == A_FREE);
            cpl_req[t]   = done_valid_i[t] && (agent_q[t] == A_BUSY);
        end
        use_cpl_d = |cpl_req;
        grant_d   = use_cpl_d || (|claim_req);
        win_d     = rr_pick(use_cpl_d ? cpl_req : claim_req, rr_q);
        rr_d      = (win_d == TW'(N_TARGET - 1)) ? '0 : win_d + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            sel_q       <= '0;
            reg_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
            err_q       <= 1'b0;
            for (int t = 0; t < N_TARGET; t++) begin
                agent_q[t] <= A_FREE;
                id_q[t]    <= '0;
            end
        end else begin
            for (int t = 0; t < N_TARGET; t++) begin
                if (agent_q[t] == A_OFFER && irq_ready_i[t]) agent_q[t] <= A_BUSY;
            end
            case (state_q)
                S_IDLE: begin
                    if (grant_d) begin
                        state_q     <= use_cpl_d ? S_COMPLETE : S_CLAIM;
                        sel_q       <= win_d;
                        rr_q        <= rr_d;
                        reg_valid_q <= 1'b1;
                        reg_write_q <= use_cpl_d;
                        reg_addr_q  <= CC_BASE + CC_STRIDE * 32'(win_d);
                        reg_wdata_q <= use_cpl_d ? 32'(id_q[win_d]) : 32'h0;
                        reg_wstrb_q <= use_cpl_d ? 4'hF : 4'h0;
                    end
                end
                S_CLAIM, S_COMPLETE: begin
                    if (reg_ready_i) begin
                        state_q     <= S_IDLE;
                        reg_valid_q <= 1'b0;
                        reg_write_q <= 1'b0;
                        reg_addr_q  <= '0;
                        reg_wdata_q <= '0;
                        reg_wstrb_q <= '0;
                        if (reg_error_i) err_q <= 1'b1;
                        if (state_q == S_COMPLETE) begin
                            agent_q[sel_q] <= A_FREE;
                        end else if (!reg_error_i && reg_rdata_i[SRCW-1:0] != '0) begin
                            // ID 0 means nothing was pending; the agent stays FREE and may retry.
                            agent_q[sel_q] <= A_OFFER;
                            id_q[sel_q]    <= reg_rdata_i[SRCW-1:0];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        irq_valid_o  = '0;
        irq_id_o     = '0;
        done_ready_o = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            irq_valid_o[t]             = (agent_q[t] == A_OFFER);
            irq_id_o[t*SRCW +: SRCW]   = id_q[t];
            done_ready_o[t]            = (state_q == S_COMPLETE) && reg_ready_i && (sel_q == TW'(t));
        end
    end

    assign reg_valid_o       = reg_valid_q;
    assign reg_write_o       = reg_write_q;
    assign reg_addr_o        = reg_addr_q;
    assign reg_wdata_o       = reg_wdata_q;
    assign reg_wstrb_o       = reg_wstrb_q;
    assign err_o             = err_q;
    assign dbg_state_o       = state_q;
    assign unused_rdata_bits = ^reg_rdata_i[31:SRCW];
endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Directed bench for plic_claim_sequencer: a cycle-by-cycle vector table plus hand-written
// sequences for bus/agent backpressure and reset during a claim.
module tb_plic_claim_sequencer;
    localparam logic [31:0] A0 = 32'h0C20_0004;
    localparam logic [31:0] A1 = 32'h0C20_1004;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  eip_i;
    logic        reg_valid_o, reg_write_o;
    logic [31:0] reg_addr_o, reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic [31:0] reg_rdata_i;
    logic        reg_ready_i, reg_error_i;
    logic [1:0]  irq_valid_o;
    logic [9:0]  irq_id_o;
    logic [1:0]  irq_ready_i, done_valid_i, done_ready_o;
    logic        err_o;
    logic [1:0]  dbg_state_o;

    plic_claim_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .eip_i(eip_i),
        .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o), .reg_rdata_i(reg_rdata_i),
        .reg_ready_i(reg_ready_i), .reg_error_i(reg_error_i),
        .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o), .irq_ready_i(irq_ready_i),
        .done_valid_i(done_valid_i), .done_ready_o(done_ready_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [1:0]  eip;
        logic [31:0] rdata;
        logic        rdy;
        logic        erri;
        logic [1:0]  irq_rdy;
        logic [1:0]  done_v;
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  irq_v;
        logic [9:0]  irq_id;
        logic [1:0]  done_r;
        logic        err;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void row(input logic rst, input logic [1:0] eip, input logic [31:0] rdata,
                                input logic rdy, input logic erri, input logic [1:0] irq_rdy,
                                input logic [1:0] done_v, input logic valid, input logic write,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic [1:0] irq_v,
                                input logic [9:0] irq_id, input logic [1:0] done_r, input logic err);
        vec_t v;
        v.rst = rst; v.eip = eip; v.rdata = rdata; v.rdy = rdy; v.erri = erri;
        v.irq_rdy = irq_rdy; v.done_v = done_v; v.valid = valid; v.write = write;
        v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.irq_v = irq_v;
        v.irq_id = irq_id; v.done_r = done_r; v.err = err;
        vq.push_back(v);
    endfunction

    // Bus payload only matters while valid and IDs only while offered, except straight after reset.
    function automatic logic [84:0] obs(input logic full, input logic mval, input logic [1:0] miv,
                                        input logic valid, input logic write,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        input logic [3:0] wstrb, input logic [1:0] iv,
                                        input logic [9:0] id, input logic [1:0] dr, input logic err);
        logic        pm;
        logic [9:0]  idm;
        pm  = full | mval;
        idm = {{5{full | miv[1]}}, {5{full | miv[0]}}};
        return {valid, pm ? write : 1'b0, pm ? addr : 32'h0, pm ? wdata : 32'h0,
                pm ? wstrb : 4'h0, iv, id & idm, dr, err};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        eip_i = '0; reg_rdata_i = '0; reg_ready_i = 1'b1; reg_error_i = 1'b0;
        irq_ready_i = '0; done_valid_i = '0;
    endtask

    initial begin
        logic        prev_rst;
        logic [84:0] a_obs, e_obs;
        vec_t        v;

        rst_i = 1'b1;
        idle_inputs();
        tick();
        tick();

        // rst  eip rdata rdy erri irqr donev | valid write addr wdata wstrb irqv irqid doner err
        row(1, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        // single claim on target 0, then completion
        row(0, 1, 7, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 1, 7, 1, 0, 0, 0,  1, 0, A0, 0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 1, 7, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 1, 10'h007, 0, 0);
        row(0, 1, 7, 1, 0, 1, 0,  0, 0, 0,  0, 4'h0, 1, 10'h007, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 0, 0, 1, 0, 0, 1,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 0, 0, 1, 0, 0, 1,  1, 1, A0, 7, 4'hF, 0, 10'h000, 1, 0);
        row(0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        // spurious claim on target 1, retried after one idle cycle
        row(0, 2, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 2, 0, 1, 0, 0, 0,  1, 0, A1, 0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 2, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 2, 0, 1, 0, 0, 0,  1, 0, A1, 0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        // arbitration: both eip from reset, then completion beats a pending claim
        row(1, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 3, 3, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 3, 3, 1, 0, 0, 0,  1, 0, A0, 0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 3, 9, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 1, 10'h003, 0, 0);
        row(0, 3, 9, 1, 0, 1, 0,  1, 0, A1, 0, 4'h0, 1, 10'h003, 0, 0);
        row(0, 3, 9, 1, 0, 2, 0,  0, 0, 0,  0, 4'h0, 2, 10'h123, 0, 0);
        row(0, 3, 0, 1, 0, 0, 2,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 3, 0, 1, 0, 0, 3,  1, 1, A1, 9, 4'hF, 0, 10'h000, 2, 0);
        row(0, 3, 0, 1, 0, 0, 1,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 3, 5, 1, 0, 0, 1,  1, 1, A0, 3, 4'hF, 0, 10'h000, 1, 0);
        row(0, 3, 5, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 3, 5, 1, 0, 0, 0,  1, 0, A1, 0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 2, 10'h0A0, 0, 0);
        // bus error on a claim
        row(1, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 2, 10'h0A0, 0, 0);
        row(0, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 1, 4, 1, 1, 0, 0,  1, 0, A0, 0, 4'h0, 0, 10'h000, 0, 0);
        // bus error on a completion
        row(1, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 1);
        row(0, 1, 4, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 1, 4, 1, 0, 0, 0,  1, 0, A0, 0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 0, 0, 1, 0, 1, 0,  0, 0, 0,  0, 4'h0, 1, 10'h004, 0, 0);
        row(0, 0, 0, 1, 0, 0, 1,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 0);
        row(0, 0, 0, 1, 1, 0, 1,  1, 1, A0, 4, 4'hF, 0, 10'h000, 1, 0);
        row(0, 1, 6, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 0, 10'h000, 0, 1);
        row(0, 1, 6, 1, 0, 0, 0,  1, 0, A0, 0, 4'h0, 0, 10'h000, 0, 1);
        row(0, 0, 0, 1, 0, 0, 0,  0, 0, 0,  0, 4'h0, 1, 10'h006, 0, 1);

        prev_rst = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            rst_i = v.rst; eip_i = v.eip; reg_rdata_i = v.rdata; reg_ready_i = v.rdy;
            reg_error_i = v.erri; irq_ready_i = v.irq_rdy; done_valid_i = v.done_v;
            #3;
            a_obs = obs(prev_rst, v.valid, v.irq_v, reg_valid_o, reg_write_o, reg_addr_o,
                        reg_wdata_o, reg_wstrb_o, irq_valid_o, irq_id_o, done_ready_o, err_o);
            e_obs = obs(prev_rst, v.valid, v.irq_v, v.valid, v.write, v.addr, v.wdata,
                        v.wstrb, v.irq_v, v.irq_id, v.done_r, v.err);
            n_vec++;
            if (a_obs !== e_obs) begin
                n_bad++;
                $display("FAIL vec%0d: got %h expected %h (valid,write,addr,wdata,wstrb,irqv,irqid,doner,err)",
                         i, a_obs, e_obs);
            end
            prev_rst = v.rst;
            tick();
        end

        // bus backpressure, then agent backpressure with eip toggling
        rst_i = 1'b1;
        idle_inputs();
        tick();
        rst_i = 1'b0; eip_i = 2'b01; reg_ready_i = 1'b0; reg_rdata_i = 32'h0B;
        tick();
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("bp_reg_valid", 32'(reg_valid_o), 32'd1);
            chk("bp_reg_addr", reg_addr_o, A0);
            chk("bp_reg_write", 32'(reg_write_o), 32'd0);
            tick();
        end
        reg_ready_i = 1'b1;
        #3;
        chk("bp_reg_valid_last", 32'(reg_valid_o), 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            eip_i = (i % 2 == 0) ? 2'b01 : 2'b00;
            irq_ready_i = 2'b00;
            reg_rdata_i = 32'h1F;
            #3;
            chk("bp_irq_valid", 32'(irq_valid_o), 32'd1);
            chk("bp_irq_id", 32'(irq_id_o[4:0]), 32'h0B);
            chk("bp_no_reclaim", 32'(reg_valid_o), 32'd0);
            tick();
        end
        irq_ready_i = 2'b01;
        #3;
        chk("bp_irq_accept", 32'(irq_valid_o), 32'd1);
        tick();
        irq_ready_i = 2'b00; eip_i = 2'b01;
        #3;
        chk("bp_busy_no_valid", 32'(irq_valid_o), 32'd0);
        tick();
        #3;
        chk("bp_busy_no_claim", 32'(reg_valid_o), 32'd0);

        // reset while a claim is waiting on the bus
        tick();
        rst_i = 1'b1;
        idle_inputs();
        tick();
        rst_i = 1'b0; eip_i = 2'b10; reg_ready_i = 1'b0;
        tick();
        #3;
        chk("rst_mid_valid", 32'(reg_valid_o), 32'd1);
        chk("rst_mid_addr", reg_addr_o, A1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; reg_ready_i = 1'b1; reg_rdata_i = 32'd2;
        #3;
        chk("rst_valid", 32'(reg_valid_o), 32'd0);
        chk("rst_write", 32'(reg_write_o), 32'd0);
        chk("rst_addr", reg_addr_o, 32'd0);
        chk("rst_wdata", reg_wdata_o, 32'd0);
        chk("rst_wstrb", 32'(reg_wstrb_o), 32'd0);
        chk("rst_irq_valid", 32'(irq_valid_o), 32'd0);
        chk("rst_irq_id", 32'(irq_id_o), 32'd0);
        chk("rst_done_ready", 32'(done_ready_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        tick();
        #3;
        chk("fresh_valid", 32'(reg_valid_o), 32'd1);
        chk("fresh_addr", reg_addr_o, A1);
        tick();
        #3;
        chk("fresh_irq_valid", 32'(irq_valid_o), 32'd2);
        chk("fresh_irq_id", 32'(irq_id_o[9:5]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
